// File: rtl/alu_serial_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq_pkg
// Description : Shared definitions for the bit-serial ALU sequencer:
//               operation encodings, ctrl field bit positions and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_serial_seq_pkg;

    // Operation encodings, ctrl[1:0]
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

    // Bit positions within ctrl = {invertA, invertB, operation[1:0]}
    localparam int CTRL_INVA  = 3;
    localparam int CTRL_INVB  = 2;
    localparam int CTRL_OP_HI = 1;
    localparam int CTRL_OP_LO = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_serial_seq_pkg
`default_nettype wire

// File: rtl/alu_serial_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq_if
// Description : Handshake and data bundle between the control unit (master)
//               and the bit-serial ALU sequencer (slave).
//   start/src1/src2/ctrl : request and operands, master -> slave
//   ready/busy/done      : handshake status, slave -> master
//   result/zero/overflow : registered result and flags, slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_serial_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic [3:0]       ctrl;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output start, src1, src2, ctrl,
        input  ready, busy, done, result, zero, overflow
    );

    modport slave (
        input  start, src1, src2, ctrl,
        output ready, busy, done, result, zero, overflow
    );
endinterface : alu_serial_seq_if
`default_nettype wire

// File: rtl/alu_serial_seq_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu_bit_slice
// Description : Combinational 1-bit ALU slice.
//   a, b              : operand bits
//   invertA, invertB  : invert the operand bit before use
//   operation         : AND / OR / ADD / SLT
//   carryIn, less     : carry into this bit, less value for SLT
//   result            : selected slice output
//   carryOut          : full-adder carry out
//   set               : full-adder sum (sign of a-b at the MSB)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_bit_slice
    import alu_serial_seq_pkg::*;
(
    input  wire logic       a,
    input  wire logic       b,
    input  wire logic       invertA,
    input  wire logic       invertB,
    input  wire logic [1:0] operation,
    input  wire logic       carryIn,
    input  wire logic       less,
    output logic            result,
    output logic            carryOut,
    output logic            set
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a      = a ^ invertA;
    assign w_b      = b ^ invertB;
    assign w_sum    = w_a ^ w_b ^ carryIn;
    assign carryOut = (w_a & w_b) | (w_a & carryIn) | (w_b & carryIn);
    assign set      = w_sum;

    always_comb begin
        result = 1'b0;
        case (operation)
            OP_AND:  result = w_a & w_b;
            OP_OR:   result = w_a | w_b;
            OP_ADD:  result = w_sum;
            OP_SLT:  result = less;
            default: result = 1'b0;
        endcase
    end

endmodule : alu_bit_slice
`default_nettype wire

// File: rtl/alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_seq
// Description : Bit-serial WIDTH-bit ALU sequencer. One 1-bit slice is reused
//               for WIDTH cycles, LSB first, with the carry recirculated.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : slave side of alu_serial_seq_if (start/ready/busy/done
//              handshake, operands, ctrl, result, zero, overflow)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_seq
    import alu_serial_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  wire logic      clk,
    input  wire logic      rst,
    alu_serial_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctrl;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_ready;
    logic             w_busy;
    logic             w_done;
    logic             w_accept;
    logic             w_last;
    logic             w_slice_res;
    logic             w_cout;
    logic             w_set;
    logic             w_ovf;
    logic [WIDTH-1:0] w_res_next;
    logic [1:0]       w_op;

    assign w_op     = r_ctrl[CTRL_OP_HI:CTRL_OP_LO];
    assign w_accept = (r_state == IDLE) && bus.start;
    assign w_last   = (r_cnt == c_last_bit);

    alu_bit_slice u_slice (
        .a         (r_a[r_cnt]),
        .b         (r_b[r_cnt]),
        .invertA   (r_ctrl[CTRL_INVA]),
        .invertB   (r_ctrl[CTRL_INVB]),
        .operation (w_op),
        .carryIn   (r_carry),
        .less      (1'b0),
        .result    (w_slice_res),
        .carryOut  (w_cout),
        .set       (w_set)
    );

    // Signed overflow only means something for the adder paths
    assign w_ovf = w_op[1] & (r_carry ^ w_cout);

    // Result after this bit is shifted in; SLT replaces the whole word with
    // the overflow-corrected sign on the final bit.
    always_comb begin
        w_res_next        = r_result;
        w_res_next[r_cnt] = w_slice_res;
        if (w_last && (w_op == OP_SLT)) begin
            w_res_next    = '0;
            w_res_next[0] = w_set ^ w_ovf;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = 1'b1;
                if (bus.start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_busy       = 1'b1;
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, bit counter, carry and result shift-in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_ctrl   <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a      <= bus.src1;
            r_b      <= bus.src2;
            r_ctrl   <= bus.ctrl;
            r_cnt    <= '0;
            // invertB with the adder means subtract: seed the +1
            r_carry  <= bus.ctrl[CTRL_INVB] & bus.ctrl[CTRL_OP_HI];
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == RUN) begin
            r_result <= w_res_next;
            r_carry  <= w_cout;
            r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_zero <= (w_res_next == '0);
                r_ovf  <= w_ovf;
            end
        end
    end

    assign bus.ready    = w_ready;
    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.result   = r_result;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;

endmodule : alu_serial_seq
`default_nettype wire

// File: tb/tb_alu_serial_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_seq
// Description : Self-checking bench for alu_serial_seq: a table of directed
//               vectors plus hand-written handshake and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_seq;

    logic clk;
    logic rst;
    int   n_err;
    int   n_checks;

    alu_serial_seq_if #(.WIDTH(32)) bus ();

    alu_serial_seq #(
        .WIDTH (32),
        .CNT_W (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [31:0] exp_result;
        logic        exp_zero;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one operation; lat counts edges from the accept edge (=1) until
    // done is seen high, capped at 100.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, output int lat);
        int g;
        @(negedge clk);
        bus.src1  = a;
        bus.src2  = b;
        bus.ctrl  = c;
        bus.start = 1'b1;
        g = 0;
        while (!bus.ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        int  k;
        logic saw_done;

        n_err    = 0;
        n_checks = 0;

        vecs[0]  = '{"add_5_3",      32'd5,          32'd3,          4'b0010, 32'd8,          1'b0, 1'b0};
        vecs[1]  = '{"sub_3_5",      32'd3,          32'd5,          4'b0110, 32'hFFFFFFFE,   1'b0, 1'b0};
        vecs[2]  = '{"sub_7_7",      32'd7,          32'd7,          4'b0110, 32'd0,          1'b1, 1'b0};
        vecs[3]  = '{"slt_m1_1",     32'hFFFFFFFF,   32'd1,          4'b0111, 32'd1,          1'b0, 1'b0};
        vecs[4]  = '{"slt_5_3",      32'd5,          32'd3,          4'b0111, 32'd0,          1'b1, 1'b0};
        vecs[5]  = '{"slt_min_max",  32'h80000000,   32'h7FFFFFFF,   4'b0111, 32'd1,          1'b0, 1'b1};
        vecs[6]  = '{"add_ovf",      32'h7FFFFFFF,   32'd1,          4'b0010, 32'h80000000,   1'b0, 1'b1};
        vecs[7]  = '{"nor_0_0",      32'd0,          32'd0,          4'b1100, 32'hFFFFFFFF,   1'b0, 1'b0};
        vecs[8]  = '{"and",          32'hF0F0F0F0,   32'hFF00FF00,   4'b0000, 32'hF000F000,   1'b0, 1'b0};
        vecs[9]  = '{"or",           32'h0F0F0000,   32'h000000F0,   4'b0001, 32'h0F0F00F0,   1'b0, 1'b0};
        vecs[10] = '{"nand_ones",    32'hFFFFFFFF,   32'hFFFFFFFF,   4'b1101, 32'd0,          1'b1, 1'b0};
        vecs[11] = '{"sub_min_1",    32'h80000000,   32'd1,          4'b0110, 32'h7FFFFFFF,   1'b0, 1'b1};

        // ---------------- reset state ----------------
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.src1  = '0;
        bus.src2  = '0;
        bus.ctrl  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready",  32'(bus.ready),    32'd1);
        chk("rst_busy",   32'(bus.busy),     32'd0);
        chk("rst_done",   32'(bus.done),     32'd0);
        chk("rst_result", bus.result,        32'd0);
        chk("rst_zero",   32'(bus.zero),     32'd0);
        chk("rst_ovf",    32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ctrl, lat);
            chk({vecs[i].name, "_latency"}, 32'(lat),          32'd33);
            chk({vecs[i].name, "_result"},  bus.result,        vecs[i].exp_result);
            chk({vecs[i].name, "_zero"},    32'(bus.zero),     32'(vecs[i].exp_zero));
            chk({vecs[i].name, "_ovf"},     32'(bus.overflow), 32'(vecs[i].exp_ovf));
        end

        // ---------------- start ignored while busy ----------------
        @(negedge clk);
        while (!bus.ready) @(negedge clk);
        bus.src1  = 32'd5;
        bus.src2  = 32'd3;
        bus.ctrl  = 4'b0010;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.src1  = 32'd100;
        bus.src2  = 32'd200;
        bus.ctrl  = 4'b0001;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("ignore_done_seen", 32'(bus.done), 32'd1);
        chk("ignore_result",    bus.result,    32'd8);
        @(posedge clk);
        #1;
        chk("ignore_no_accept", 32'(bus.busy), 32'd0);

        // ---------------- start held high ----------------
        @(negedge clk);
        bus.src1  = 32'd1;
        bus.src2  = 32'd1;
        bus.ctrl  = 4'b0010;
        bus.start = 1'b1;
        k = 0;
        while (!bus.done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("held_first_done", 32'(bus.done), 32'd1);
        @(posedge clk);
        #1;
        chk("held_idle_ready", 32'(bus.ready), 32'd1);
        @(posedge clk);
        #1;
        chk("held_reaccept", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("held_latency", 32'(lat),   32'd33);
        chk("held_result",  bus.result, 32'd2);

        // ---------------- asynchronous reset mid-RUN ----------------
        @(negedge clk);
        while (!bus.ready) @(negedge clk);
        bus.src1  = 32'h000000FF;
        bus.src2  = 32'd0;
        bus.ctrl  = 4'b0010;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_ready",  32'(bus.ready),    32'd1);
        chk("arst_busy",   32'(bus.busy),     32'd0);
        chk("arst_done",   32'(bus.done),     32'd0);
        chk("arst_result", bus.result,        32'd0);
        chk("arst_zero",   32'(bus.zero),     32'd0);
        chk("arst_ovf",    32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("arst_no_done", 32'(saw_done), 32'd0);
        run_op(32'd2, 32'd2, 4'b0010, lat);
        chk("arst_after_latency", 32'(lat),   32'd33);
        chk("arst_after_result",  bus.result, 32'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_alu_serial_seq
`default_nettype wire

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial WIDTH-bit ALU sequencer: reuses one 1-bit ALU slice for WIDTH cycles, LSB first.
- Recirculates the slice carry-out into the next cycle's carry-in.
- Resolves set-less-than by writing the MSB-derived set into result bit 0 after the final bit.
- Sits between the control unit and the slice; offers a start/ready/done handshake plus zero and overflow flags.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
CNT_W, 5, bit-counter width; must satisfy 2**CNT_W ≥ WIDTH

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
start  input  1  request; accepted only when ready=1
src1  input  WIDTH  operand A, latched on accept
src2  input  WIDTH  operand B, latched on accept
ctrl  input  4  {invertA, invertB, operation[1:0]}; op 00 AND, 01 OR, 10 ADD, 11 SLT; latched on accept
ready  output  1  high in IDLE only
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse: result and flags valid
result  output  WIDTH  registered result, held until next accept
zero  output  1  result == 0, registered with result
overflow  output  1  signed overflow for ADD/SLT; 0 for AND/OR

Behaviour:
- Interface: one clock; reset is asynchronous and active-high, on ports clk and rst.
- Reset, asynchronous, any state including mid-RUN: state=IDLE, ready=1, busy=0, done=0, result=0, zero=0, overflow=0, counter=0, carry=0. The operation in flight is discarded with no done pulse.
- States:
  - IDLE→RUN on start.
  - RUN→RUN while counter<WIDTH-1.
  - RUN→DONE on the edge processing bit WIDTH-1.
  - DONE→IDLE unconditionally.
- Accept edge:
  - Latch src1, src2 and ctrl; counter=0.
  - carry = invertB & operation[1], so ADD with invertB=1 is subtract.
  - Clear the result register.
- RUN, each edge:
  - Slice inputs: a=A[counter], b=B[counter], inversions from the latched ctrl, carryIn=carry, less=0.
  - result[counter] = slice result; carry = slice carryOut; counter increments.
- Last bit (counter=WIDTH-1):
  - overflow = operation[1] & (carryIn_msb ^ carryOut_msb).
  - For SLT: result[0] = set_msb ^ overflow (signed-correct less-than); bits WIDTH-1..1 = 0.
  - zero is computed from the final result value.
- done=1 exactly during DONE (one cycle). Latency from accept edge to done high = WIDTH+1 edges (33 for default).
- start is ignored while busy; operands changing during RUN have no effect.
- start held high continuously: the next accept occurs in the cycle after DONE (IDLE), so back-to-back throughput is one operation per WIDTH+2 cycles.
- Logical ops: the carry chain is still computed, but overflow is forced to 0.
- NOR/NAND fall out of invertA=invertB=1 with AND/OR.

Decomposition:
- Shared package holds:
  - operation encodings OP_AND=2'b00, OP_OR=2'b01, OP_ADD=2'b10, OP_SLT=2'b11;
  - ctrl field bit positions;
  - FSM state encodings IDLE/RUN/DONE.
- One sub-module, alu_bit_slice: combinational 1-bit slice (inputs a, b, invertA, invertB, operation, carryIn, less; outputs result, carryOut, set), instantiated once.
- Counter, FSM and result shift-in logic live in alu_serial_seq.

Test Plan:
- ADD: src1=5, src2=3, ctrl=4'b0010 → done exactly 33 cycles after accept; result=8, zero=0, overflow=0.
- SUB: src1=3, src2=5, ctrl=4'b0110 → result=32'hFFFFFFFE, overflow=0. Then src1=src2=7 → result=0, zero=1.
- SLT:
  - src1=32'hFFFFFFFF, src2=1, ctrl=4'b0111 → result=1.
  - src1=5, src2=3 → result=0.
  - src1=32'h80000000, src2=32'h7FFFFFFF → result=1, overflow=1.
- Overflow/logic:
  - 32'h7FFFFFFF+1 (ADD) → result=32'h80000000, overflow=1.
  - NOR ctrl=4'b1100 on 0,0 → 32'hFFFFFFFF, overflow=0.
- Handshake:
  - Pulse start again at cycle 10 of RUN with different operands → ignored; the original result is returned.
  - start held high → accepts exactly one cycle after each done.
- Reset: assert rst at cycle 15 of RUN, asynchronously mid-cycle → outputs zero immediately, ready=1, no done pulse. A fresh ADD 2+2 afterwards returns 4.
